// File: rtl/tart_bank_control.sv
// Purpose : correlator bank controller; counts samples per block, swaps write bank, tracks unread banks.
// Latency : swap_o pulses PIPE cycles after the block-terminating strobe; flags are registered (1 cycle).
// Backpr. : none on strobe_i; when every bank is unread a swap reuses the current bank and sets overflow_o.
//
// Ports
//   clk_i, rst_ni        correlator clock, asynchronous active-low reset
//   ce_i, strobe_i       count enable and new-sample strobe; a sample counts when both are high
//   bcount_i             block size minus 1, compared live against the running count
//   ack_i                readout of rd_bank_o finished (ignored when nothing is unread)
//   clear_i              clears the sticky overflow flag
//   swap_o               one-cycle bank-swap pulse
//   bank_o, rd_bank_o    bank being written, oldest completed bank
//   level_o              number of completed, unread banks
//   avail_o, full_o      level_o != 0, level_o == BANKS-1
//   overflow_o           sticky: a completed block was lost
module tart_bank_control #(
  parameter int COUNT = 24,
  parameter int ABITS = 2,
  parameter int PIPE  = 4,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [COUNT-1:0] bcount_i,
  input  logic             strobe_i,
  input  logic             ack_i,
  input  logic             clear_i,
  output logic             swap_o,
  output logic [ABITS-1:0] bank_o,
  output logic [ABITS-1:0] rd_bank_o,
  output logic [ABITS-1:0] level_o,
  output logic             avail_o,
  output logic             full_o,
  output logic             overflow_o
);

  // DELAY is a simulation-only assignment delay kept for drop-in compatibility;
  // this RTL models no delays, so it only takes part in the parameter sanity check.
  if (PIPE < 1 || PIPE > 15 || ABITS < 1 || COUNT < 1 || DELAY < 0) begin : g_param_check
    $error("tart_bank_control: parameter out of range");
  end

  // BANKS-1 is the all-ones value of an ABITS-wide field.
  localparam logic [ABITS-1:0] LVL_MAX = '1;

  // ---------------------------------------------------------------------------
  // Sample counter
  // ---------------------------------------------------------------------------
  logic [COUNT-1:0] count_q;
  logic             hit;
  logic             wrap;

  assign hit  = ce_i & strobe_i;
  // >= rather than == so a bcount_i lowered mid-block still ends the block.
  assign wrap = (count_q >= bcount_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (hit) begin
      count_q <= wrap ? '0 : count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Swap delay line: free-running, so a swap still issues if ce_i drops.
  // Reset flushes it, discarding any pending swap.
  // ---------------------------------------------------------------------------
  logic [PIPE-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= hit & wrap;
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign swap_o = pipe_q[PIPE-1];

  // ---------------------------------------------------------------------------
  // Bank pointers and occupancy
  // ---------------------------------------------------------------------------
  logic             ack_ok;
  logic             ovf_set;
  logic [ABITS-1:0] bank_d;
  logic [ABITS-1:0] rd_d;
  logic [ABITS-1:0] level_d;

  assign ack_ok = ack_i & avail_o;

  always_comb begin
    bank_d  = bank_o;
    rd_d    = rd_bank_o;
    level_d = level_o;
    ovf_set = 1'b0;
    case ({swap_o, ack_ok})
      // A readout frees a bank in the same cycle, so even when full the swap is safe.
      2'b11: begin
        bank_d = bank_o + 1'b1;
        rd_d   = rd_bank_o + 1'b1;
      end
      2'b10: begin
        if (full_o) begin
          // No free bank: keep writing the current one and flag the lost block.
          ovf_set = 1'b1;
        end else begin
          bank_d  = bank_o + 1'b1;
          level_d = level_o + 1'b1;
        end
      end
      2'b01: begin
        rd_d    = rd_bank_o + 1'b1;
        level_d = level_o - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_o     <= '0;
      rd_bank_o  <= '0;
      level_o    <= '0;
      avail_o    <= 1'b0;
      full_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      bank_o     <= bank_d;
      rd_bank_o  <= rd_d;
      level_o    <= level_d;
      // Flags come from the same next value as level_o so all three agree every cycle.
      avail_o    <= (level_d != '0);
      full_o     <= (level_d == LVL_MAX);
      // Set wins over a simultaneous clear.
      overflow_o <= ovf_set | (overflow_o & ~clear_i);
    end
  end

endmodule
